// File: rtl/fast_subtractor_4stage.sv
// fast_subtractor_4stage
// Pipelined subtractor computing out_diff = in_a - in_b as in_a + ~in_b + 1.
// One carry-lookahead slice of SLICE bits is resolved per pipeline stage and the
// inter-slice carry is registered between stages. Valid/ready handshaking uses a
// single global advance signal, so a stall freezes every stage, bubbles included.
// The final stage register drives every out_* port directly.

module fast_subtractor_4stage #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8,
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int STAGES = WIDTH / SLICE;
    localparam int LAST   = STAGES - 1;

    // Carry-lookahead adder slice: every carry is formed directly from the
    // generate/propagate terms and the slice carry-in (sum-of-products form).
    // Returns {carry_out, sum}.
    function automatic logic [SLICE:0] cla_slice(
        input logic [SLICE-1:0] a,
        input logic [SLICE-1:0] b,
        input logic             cin
    );
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] p;
        logic [SLICE:0]   c;
        logic             term;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        term = 1'b0;
        for (int i = 0; i <= SLICE; i++) begin
            term = cin;
            for (int m = 0; m < i; m++) begin
                term = term & p[m];
            end
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) begin
                    term = term & p[m];
                end
                c[i] = c[i] | term;
            end
        end
        return {c[SLICE], p ^ c[SLICE-1:0]};
    endfunction

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !reset;

    // Slice 0 works straight off the operands with carry-in 1 (the +1 of two's complement).
    logic [SLICE-1:0] s0_sum;
    logic             s0_cout;

    assign {s0_cout, s0_sum} = cla_slice(in_a[SLICE-1:0], ~in_b[SLICE-1:0], 1'b1);

    genvar k;
    generate
        for (k = 1; k < STAGES; k++) begin : g_stage
            localparam int LO   = k * SLICE;
            localparam int HI_W = WIDTH - LO;

            logic             valid_q;
            logic [LO-1:0]    diff_q;
            logic             carry_q;
            logic [HI_W-1:0]  a_hi_q;
            logic [HI_W-1:0]  nb_hi_q;
            logic [TAG_W-1:0] tag_q;

            logic             nxt_valid;
            logic [LO-1:0]    nxt_diff;
            logic             nxt_carry;
            logic [HI_W-1:0]  nxt_a_hi;
            logic [HI_W-1:0]  nxt_nb_hi;
            logic [TAG_W-1:0] nxt_tag;

            if (k == 1) begin : g_first
                assign nxt_valid = in_valid;
                assign nxt_diff  = s0_sum;
                assign nxt_carry = s0_cout;
                assign nxt_a_hi  = in_a[WIDTH-1:SLICE];
                assign nxt_nb_hi = ~in_b[WIDTH-1:SLICE];
                assign nxt_tag   = in_tag;
            end else begin : g_mid
                logic [SLICE-1:0] sum;
                logic             cout;

                assign {cout, sum} = cla_slice(g_stage[k-1].a_hi_q[SLICE-1:0],
                                               g_stage[k-1].nb_hi_q[SLICE-1:0],
                                               g_stage[k-1].carry_q);
                assign nxt_valid = g_stage[k-1].valid_q;
                assign nxt_diff  = {sum, g_stage[k-1].diff_q};
                assign nxt_carry = cout;
                assign nxt_a_hi  = g_stage[k-1].a_hi_q[WIDTH-(k-1)*SLICE-1:SLICE];
                assign nxt_nb_hi = g_stage[k-1].nb_hi_q[WIDTH-(k-1)*SLICE-1:SLICE];
                assign nxt_tag   = g_stage[k-1].tag_q;
            end

            // Stage register: cleared on reset, frozen whenever the output is stalled.
            always_ff @(posedge clock) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    diff_q  <= '0;
                    carry_q <= 1'b0;
                    a_hi_q  <= '0;
                    nb_hi_q <= '0;
                    tag_q   <= '0;
                end else if (advance) begin
                    valid_q <= nxt_valid;
                    diff_q  <= nxt_diff;
                    carry_q <= nxt_carry;
                    a_hi_q  <= nxt_a_hi;
                    nb_hi_q <= nxt_nb_hi;
                    tag_q   <= nxt_tag;
                end
            end
        end
    endgenerate

    // Final slice resolves the top bits and the flags from the last intermediate stage.
    logic [SLICE-1:0] fin_sum;
    logic             fin_cout;
    logic             fin_a_msb;
    logic             fin_b_msb;

    assign {fin_cout, fin_sum} = cla_slice(g_stage[LAST].a_hi_q,
                                           g_stage[LAST].nb_hi_q,
                                           g_stage[LAST].carry_q);
    assign fin_a_msb = g_stage[LAST].a_hi_q[SLICE-1];
    assign fin_b_msb = ~g_stage[LAST].nb_hi_q[SLICE-1];

    // Output stage register: holds the result steady while the consumer stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_diff   <= '0;
            out_borrow <= 1'b0;
            out_ovf    <= 1'b0;
            out_tag    <= '0;
        end else if (advance) begin
            out_valid  <= g_stage[LAST].valid_q;
            out_diff   <= {fin_sum, g_stage[LAST].diff_q};
            out_borrow <= ~fin_cout;
            out_ovf    <= (fin_a_msb != fin_b_msb) && (fin_sum[SLICE-1] != fin_a_msb);
            out_tag    <= g_stage[LAST].tag_q;
        end
    end

endmodule

// File: tb/tb_fast_subtractor_4stage.sv
// tb_fast_subtractor_4stage
// Directed self-checking bench for the pipelined subtractor. Inputs change and
// outputs are sampled on the falling clock edge, away from the active edge.

module tb_fast_subtractor_4stage;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_diff;
    logic        out_borrow;
    logic        out_ovf;
    logic [3:0]  out_tag;

    int n_checks = 0;
    int n_fail   = 0;

    fast_subtractor_4stage #(.WIDTH(32), .SLICE(8), .TAG_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_diff   (out_diff),
        .out_borrow (out_borrow),
        .out_ovf    (out_ovf),
        .out_tag    (out_tag)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic test_reset;
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_a      = 32'h0000_0005;
        in_b      = 32'h0000_0003;
        in_tag    = 4'h3;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid);
            end
            n_checks++;
            if (out_diff !== 32'h0) begin
                n_fail++;
                $display("[TB] FAIL reset_out_diff: got %h expected 00000000", out_diff);
            end
            n_checks++;
            if (out_borrow !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_out_borrow: got %0b expected 0", out_borrow);
            end
            n_checks++;
            if (out_tag !== 4'h0) begin
                n_fail++;
                $display("[TB] FAIL reset_out_tag: got %h expected 0", out_tag);
            end
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_in_ready: got %0b expected 0", in_ready);
            end
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_no_ghost cycle %0d: got %0b expected 0", c, out_valid);
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_single;
        in_valid  = 1'b1;
        in_a      = 32'h0000_0005;
        in_b      = 32'h0000_0003;
        in_tag    = 4'h3;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL single_in_ready: got %0b expected 1", in_ready);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            in_valid = 1'b0;
            n_checks++;
            if (out_valid !== (c == 3)) begin
                n_fail++;
                $display("[TB] FAIL single_valid_edge_N+%0d: got %0b expected %0b", c, out_valid, (c == 3));
            end
            if (c == 3) begin
                n_checks++;
                if (out_diff !== 32'h0000_0002) begin
                    n_fail++;
                    $display("[TB] FAIL single_diff: got %h expected 00000002", out_diff);
                end
                n_checks++;
                if (out_borrow !== 1'b0 || out_ovf !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL single_flags: got borrow=%0b ovf=%0b expected 0 0", out_borrow, out_ovf);
                end
                n_checks++;
                if (out_tag !== 4'h3) begin
                    n_fail++;
                    $display("[TB] FAIL single_tag: got %h expected 3", out_tag);
                end
            end
        end
        $display("[TB] test_single done");
    endtask

    task automatic test_chain;
        logic [31:0] va [4] = '{32'h0000_0000, 32'h8000_0000, 32'h1234_5678, 32'h7FFF_FFFF};
        logic [31:0] vb [4] = '{32'h0000_0001, 32'h0000_0001, 32'h1234_5678, 32'hFFFF_FFFF};
        logic [31:0] ed [4] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        logic        eb [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic        eo [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            in_valid = 1'b1;
            in_a     = va[v];
            in_b     = vb[v];
            in_tag   = 4'(4'hA + v);
            @(negedge clock);
            in_valid = 1'b0;
            @(negedge clock);
            @(negedge clock);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL chain_early_valid v%0d: got %0b expected 0", v, out_valid);
            end
            @(negedge clock);
            n_checks++;
            if (out_valid !== 1'b1 || out_diff !== ed[v]) begin
                n_fail++;
                $display("[TB] FAIL chain_diff v%0d: got valid=%0b diff=%h expected valid=1 diff=%h",
                         v, out_valid, out_diff, ed[v]);
            end
            n_checks++;
            if (out_borrow !== eb[v] || out_ovf !== eo[v]) begin
                n_fail++;
                $display("[TB] FAIL chain_flags v%0d: got borrow=%0b ovf=%0b expected borrow=%0b ovf=%0b",
                         v, out_borrow, out_ovf, eb[v], eo[v]);
            end
            n_checks++;
            if (out_tag !== 4'(4'hA + v)) begin
                n_fail++;
                $display("[TB] FAIL chain_tag v%0d: got %h expected %h", v, out_tag, 4'(4'hA + v));
            end
        end
        $display("[TB] test_chain done");
    endtask

    task automatic test_back_to_back;
        logic [31:0] ed [8] = '{32'hFF00_FF01, 32'h0002_0002, 32'h0103_0103, 32'h0204_0204,
                                32'h0305_0305, 32'h0406_0406, 32'h0507_0507, 32'h0608_0608};
        logic        eb [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            if (t < 8) begin
                in_valid = 1'b1;
                in_a     = 32'h0101_0101 * t;
                in_b     = 32'h00FF_00FF;
                in_tag   = 4'(t);
                #1;
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_in_ready t%0d: got %0b expected 1", t, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clock);
            if (t >= 3 && t < 11) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_tag !== 4'(t - 3) || out_diff !== ed[t-3] ||
                    out_borrow !== eb[t-3]) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_result t%0d: got valid=%0b tag=%h diff=%h borrow=%0b expected valid=1 tag=%h diff=%h borrow=%0b",
                             t, out_valid, out_tag, out_diff, out_borrow, 4'(t - 3), ed[t-3], eb[t-3]);
                end
            end else begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_idle t%0d: got valid=%0b expected 0", t, out_valid);
                end
            end
        end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_stall;
        logic [31:0] ed [6] = '{32'h1000_0000, 32'h0FFF_FFFF, 32'h0FFF_FFFE,
                                32'h0FFF_FFFD, 32'h0FFF_FFFC, 32'h0FFF_FFFB};
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            in_valid = 1'b1;
            in_a     = 32'h1000_0000;
            in_b     = 32'(t);
            in_tag   = 4'(8 + t);
            @(negedge clock);
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'h8) begin
            n_fail++;
            $display("[TB] FAIL stall_fill: got valid=%0b tag=%h expected valid=1 tag=8", out_valid, out_tag);
        end
        in_valid  = 1'b1;
        in_b      = 32'd4;
        in_tag    = 4'hC;
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL stall_in_ready s%0d: got %0b expected 0", s, in_ready);
            end
            @(negedge clock);
            n_checks++;
            if (out_valid !== 1'b1 || out_diff !== ed[0] || out_tag !== 4'h8 || out_borrow !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL stall_hold s%0d: got valid=%0b diff=%h tag=%h borrow=%0b expected valid=1 diff=%h tag=8 borrow=0",
                         s, out_valid, out_diff, out_tag, out_borrow, ed[0]);
            end
        end
        out_ready = 1'b1;
        for (int s = 0; s < 6; s++) begin
            if (s == 0) begin
                #1;
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL stall_release_in_ready: got %0b expected 1", in_ready);
                end
            end else if (s == 1) begin
                in_b   = 32'd5;
                in_tag = 4'hD;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clock);
            if (s < 5) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_tag !== 4'(9 + s) || out_diff !== ed[s+1]) begin
                    n_fail++;
                    $display("[TB] FAIL stall_drain s%0d: got valid=%0b tag=%h diff=%h expected valid=1 tag=%h diff=%h",
                             s, out_valid, out_tag, out_diff, 4'(9 + s), ed[s+1]);
                end
            end else begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL stall_drain_end: got valid=%0b expected 0", out_valid);
                end
            end
        end
        $display("[TB] test_stall done");
    endtask

    task automatic test_reset_flush;
        out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            in_valid = 1'b1;
            in_a     = 32'h0000_0055;
            in_b     = 32'(t);
            in_tag   = 4'(1 + t);
            @(negedge clock);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        n_checks++;
        if (out_valid !== 1'b0 || out_diff !== 32'h0 || out_tag !== 4'h0 || out_borrow !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_reset_edge: got valid=%0b diff=%h tag=%h borrow=%0b expected all 0",
                     out_valid, out_diff, out_tag, out_borrow);
        end
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL flush_ghost c%0d: got valid=%0b tag=%h expected valid=0", c, out_valid, out_tag);
            end
        end
        in_valid = 1'b1;
        in_a     = 32'h0000_0100;
        in_b     = 32'h0000_0001;
        in_tag   = 4'hE;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            in_valid = 1'b0;
            n_checks++;
            if (out_valid !== (c == 3)) begin
                n_fail++;
                $display("[TB] FAIL flush_new_latency N+%0d: got valid=%0b expected %0b", c, out_valid, (c == 3));
            end
        end
        n_checks++;
        if (out_diff !== 32'h0000_00FF || out_tag !== 4'hE || out_borrow !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_new_result: got diff=%h tag=%h borrow=%0b expected diff=000000ff tag=e borrow=0",
                     out_diff, out_tag, out_borrow);
        end
        $display("[TB] test_reset_flush done");
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        test_reset();
        test_single();
        test_chain();
        test_back_to_back();
        test_stall();
        test_reset_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
